// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl
// Sequencer for the iterative multiply/divide unit and the HI/LO pair.
// Accepts one mul/div at a time, runs WIDTH shift-add or restoring-divide
// steps, applies sign correction in a final FIX cycle and writes HI/LO.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   valid, func, a, b  request from the execute stage (func = ALU function)
//   cancel             exception flush, aborts any in-flight operation
//   stall              combinational, hold the execute stage
//   busy               registered, an operation is in flight
//   result             combinational Mfhi/Mflo read data (0 otherwise)
//   hi, lo             HI/LO registers
module alu_muldiv_ctrl #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 5,
  parameter logic [FUNC_W-1:0] FUNC_MULS = 5'd10,
  parameter logic [FUNC_W-1:0] FUNC_MULU = 5'd11,
  parameter logic [FUNC_W-1:0] FUNC_DIVS = 5'd12,
  parameter logic [FUNC_W-1:0] FUNC_DIVU = 5'd13,
  parameter logic [FUNC_W-1:0] FUNC_MFHI = 5'd14,
  parameter logic [FUNC_W-1:0] FUNC_MFLO = 5'd15,
  parameter logic [FUNC_W-1:0] FUNC_MTHI = 5'd16,
  parameter logic [FUNC_W-1:0] FUNC_MTLO = 5'd17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cancel,
  output logic              stall,
  output logic              busy,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Two's complement negation helpers for single and double width values.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + ONE_2W;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_mul_q, is_mul_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               div0_q, div0_d;

  logic               f_muls, f_mulu, f_divs, f_divu;
  logic               f_mfhi, f_mflo, f_mthi, f_mtlo;
  logic               f_muldiv, f_handled, f_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign f_muls    = (func == FUNC_MULS);
  assign f_mulu    = (func == FUNC_MULU);
  assign f_divs    = (func == FUNC_DIVS);
  assign f_divu    = (func == FUNC_DIVU);
  assign f_mfhi    = (func == FUNC_MFHI);
  assign f_mflo    = (func == FUNC_MFLO);
  assign f_mthi    = (func == FUNC_MTHI);
  assign f_mtlo    = (func == FUNC_MTLO);
  assign f_muldiv  = f_muls | f_mulu | f_divs | f_divu;
  assign f_handled = f_muldiv | f_mfhi | f_mflo | f_mthi | f_mtlo;
  assign f_signed  = f_muls | f_divs;

  assign a_neg = f_signed & a[WIDTH-1];
  assign b_neg = f_signed & b[WIDTH-1];
  assign a_mag = a_neg ? neg_w(a) : a;
  assign b_mag = b_neg ? neg_w(b) : b;

  // Shift-add step: add multiplicand on LSB=1, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
  // The remainder stays below the divisor, so the difference always fits WIDTH bits.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  assign prod_fix = q_neg_q ? neg_2w(acc_q) : acc_q;
  assign quo_fix  = q_neg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = r_neg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  assign stall = valid & busy_q & f_handled;
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Mfhi/Mflo read port; zero unless a read is presented while idle.
  always_comb begin
    result = ZERO_W;
    if (valid && !busy_q && f_mfhi) begin
      result = hi_q;
    end else if (valid && !busy_q && f_mflo) begin
      result = lo_q;
    end else begin
      result = ZERO_W;
    end
  end

  // Next-state, datapath step and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_mul_d = is_mul_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    if (cancel) begin
      // Flush wins over everything in flight; HI/LO keep their values.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid && f_muldiv) begin
            is_mul_d = f_muls | f_mulu;
            opnd_d   = (f_muls | f_mulu) ? a_mag : b_mag;
            acc_d    = {ZERO_W, ((f_muls | f_mulu) ? b_mag : a_mag)};
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            div0_d   = (b == ZERO_W);
            a_raw_d  = a;
            cnt_d    = CNT_MAX;
            state_d  = ST_CALC;
          end else if (valid && f_mthi) begin
            hi_d = a;
          end else if (valid && f_mtlo) begin
            lo_d = a;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_d = is_mul_q ? mul_next : div_next;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FIX: begin
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (div0_q) begin
            // Divide by zero: fixed, trap-free result independent of signedness.
            hi_d = a_raw_q;
            lo_d = ONES_W;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // State, counter, operand and HI/LO registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      hi_q     <= ZERO_W;
      lo_q     <= ZERO_W;
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= ZERO_W;
      a_raw_q  <= ZERO_W;
      is_mul_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      is_mul_q <= is_mul_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed self-checking bench for alu_muldiv_ctrl (WIDTH=32).
module tb_alu_muldiv_ctrl;

  localparam logic [4:0] F_ADD  = 5'd0;
  localparam logic [4:0] F_MULS = 5'd10;
  localparam logic [4:0] F_MULU = 5'd11;
  localparam logic [4:0] F_DIVS = 5'd12;
  localparam logic [4:0] F_DIVU = 5'd13;
  localparam logic [4:0] F_MFHI = 5'd14;
  localparam logic [4:0] F_MFLO = 5'd15;
  localparam logic [4:0] F_MTHI = 5'd16;
  localparam logic [4:0] F_MTLO = 5'd17;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [4:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass   = 0;
  int n_checks = 0;

  alu_muldiv_ctrl #(
    .WIDTH (32),
    .FUNC_W(5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .valid (valid),
    .func  (func),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .stall (stall),
    .busy  (busy),
    .result(result),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a mul/div from idle, then count cycles with busy high (bounded).
  task automatic run_op(input logic [4:0] f, input logic [31:0] ta, input logic [31:0] tb_v,
                        output int cyc);
    valid = 1'b1;
    func  = f;
    a     = ta;
    b     = tb_v;
    step();
    valid = 1'b0;
    func  = F_ADD;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic muldiv_case(input string tag, input logic [4:0] f, input logic [31:0] ta,
                             input logic [31:0] tb_v, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
    int cyc;
    run_op(f, ta, tb_v, cyc);
    check_eq({tag, ".busy_cycles"}, 64'(cyc), 64'd33);
    check_eq({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset  = 1'b1;
    valid  = 1'b0;
    func   = F_ADD;
    a      = 32'd0;
    b      = 32'd0;
    cancel = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("reset.hi", 64'(hi), 64'd0);
    check_eq("reset.lo", 64'(lo), 64'd0);
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.stall", 64'(stall), 64'd0);
    check_eq("reset.result", 64'(result), 64'd0);

    // Arithmetic vectors with hand-computed results.
    muldiv_case("mulu_3x5", F_MULU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    muldiv_case("muls_m1x2", F_MULS, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    muldiv_case("muls_m3x7", F_MULS, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    muldiv_case("divs_m7d2", F_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    muldiv_case("divs_7dm2", F_DIVS, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    muldiv_case("divu_100d7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    muldiv_case("divu_7d0", F_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
    muldiv_case("divs_m7d0", F_DIVS, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    muldiv_case("divs_ovf", F_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Move-to / move-from while idle.
    valid = 1'b1;
    func  = F_MTHI;
    a     = 32'h1234_5678;
    #1;
    check_eq("mthi.stall", 64'(stall), 64'd0);
    step();
    func = F_MFHI;
    #1;
    check_eq("mfhi.stall", 64'(stall), 64'd0);
    check_eq("mfhi.result", 64'(result), 64'h1234_5678);
    func = F_MTLO;
    a    = 32'hCAFE_F00D;
    step();
    func = F_MFLO;
    #1;
    check_eq("mflo.result", 64'(result), 64'hCAFE_F00D);
    check_eq("mthi.hi_kept", 64'(hi), 64'h1234_5678);
    valid = 1'b0;
    #1;
    check_eq("noread.result", 64'(result), 64'd0);

    // Mflo presented during a divide stalls until completion, then sees the quotient.
    valid = 1'b1;
    func  = F_DIVU;
    a     = 32'd1000;
    b     = 32'd10;
    step();
    func = F_MFLO;
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
    check_eq("mflo_wait.stall_cycles", 64'(cyc), 64'd33);
    check_eq("mflo_wait.result", 64'(result), 64'd100);
    check_eq("mflo_wait.hi", 64'(hi), 64'd0);
    step();
    valid = 1'b0;
    func  = F_ADD;

    // Cancel in the middle of a multiply leaves HI/LO untouched.
    valid = 1'b1;
    func  = F_MTHI;
    a     = 32'h0000_000A;
    step();
    func = F_MTLO;
    a    = 32'h0000_000B;
    step();
    func = F_MULU;
    a    = 32'h0000_1234;
    b    = 32'h0000_5678;
    step();
    valid = 1'b0;
    func  = F_ADD;
    repeat (8) step();
    valid = 1'b1;
    #1;
    check_eq("busy_other.stall", 64'(stall), 64'd0);
    check_eq("busy_other.busy", 64'(busy), 64'd1);
    step();
    valid  = 1'b0;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_eq("cancel.busy", 64'(busy), 64'd0);
    check_eq("cancel.hi", 64'(hi), 64'h0000_000A);
    check_eq("cancel.lo", 64'(lo), 64'h0000_000B);
    repeat (40) step();
    check_eq("cancel.hi_later", 64'(hi), 64'h0000_000A);
    check_eq("cancel.lo_later", 64'(lo), 64'h0000_000B);

    // Requests presented together with cancel are dropped.
    cancel = 1'b1;
    valid  = 1'b1;
    func   = F_MTHI;
    a      = 32'h0000_DEAD;
    step();
    check_eq("cancel_mthi.hi", 64'(hi), 64'h0000_000A);
    func = F_MULU;
    a    = 32'd3;
    b    = 32'd5;
    step();
    cancel = 1'b0;
    valid  = 1'b0;
    func   = F_ADD;
    check_eq("cancel_mul.busy", 64'(busy), 64'd0);

    // Reset in the middle of a signed divide.
    valid = 1'b1;
    func  = F_DIVS;
    a     = 32'd100;
    b     = 32'd3;
    step();
    valid = 1'b0;
    func  = F_ADD;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midreset.hi", 64'(hi), 64'd0);
    check_eq("midreset.lo", 64'(lo), 64'd0);
    check_eq("midreset.busy", 64'(busy), 64'd0);
    valid = 1'b1;
    func  = F_MFLO;
    #1;
    check_eq("midreset.stall", 64'(stall), 64'd0);
    valid = 1'b0;
    func  = F_ADD;
    muldiv_case("mulu_max", F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
